// File: rtl/noc_pkg.sv
// Shared NoC router defaults and helpers: default flit/port/buffer sizes,
// credit counter width and one-hot to index conversion.
package noc_pkg;

  localparam int FW_DEF = 64;
  localparam int P_DEF  = 7;
  localparam int B_DEF  = 4;

  // A buffer of 2^b flits needs b+1 bits to hold the full credit count.
  function automatic int cred_w(input int b);
    return b + 1;
  endfunction

  function automatic int onehot_to_idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker with a registered pointer; the search starts just after
// the last winner and wraps. The pointer resets to P-1 so input 0 wins first.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int P = P_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [P-1:0] req,
  input  logic         enable,
  output logic [P-1:0] gnt_nxt
);

  localparam int PW = (P > 1) ? $clog2(P) : 1;

  logic [PW-1:0] ptr;
  logic          found;
  int            idx;

  always_comb begin
    gnt_nxt = '0;
    found   = 1'b0;
    idx     = 0;
    if (enable) begin
      for (int k = 1; k <= P; k++) begin
        idx = (int'(ptr) + k) % P;
        if (!found && req[idx]) begin
          gnt_nxt[idx] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= PW'(P - 1);
    end else if (gnt_nxt != '0) begin
      ptr <= PW'(onehot_to_idx(32'(gnt_nxt)));
    end
  end

endmodule

// File: rtl/output_port.sv
// NoC router output port: round-robin grant, registered flit mux and downstream
// credit counter. Optional credit-protocol checker under OUTPUT_PORT_CREDIT_CHK_EN.
module output_port
  import noc_pkg::*;
#(
  parameter int FW = FW_DEF,
  parameter int P  = P_DEF,
  parameter int B  = B_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [P-1:0]    port_req,
  input  logic [P*FW-1:0] flits_in,
  output logic [P-1:0]    grant,
  output logic [FW-1:0]   flit_out,
  output logic            flit_out_wr,
  input  logic            credit_in,
  output logic [B:0]      credit_cnt,
  output logic            cred_err
);

  localparam int         CW   = cred_w(B);
  localparam logic [B:0] FULL = {1'b1, {B{1'b0}}};

  logic [P-1:0]  eff_req;
  logic [P-1:0]  gnt_nxt;
  logic          arb_en;
  logic          dec;
  logic [FW-1:0] flit_sel;

  // A requester is still high during its own grant cycle, so mask it out.
  assign eff_req = port_req & ~grant;
  assign arb_en  = (credit_cnt != '0);
  assign dec     = (gnt_nxt != '0);

  rr_arbiter #(.P(P)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (eff_req),
    .enable  (arb_en),
    .gnt_nxt (gnt_nxt)
  );

  always_comb begin
    flit_sel = '0;
    for (int i = 0; i < P; i++) begin
      if (grant[i]) flit_sel = flits_in[i*FW +: FW];
    end
  end

  // Stage 1: registered grant; stage 2: registered link flit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant       <= '0;
      flit_out    <= '0;
      flit_out_wr <= 1'b0;
    end else begin
      grant       <= gnt_nxt;
      flit_out_wr <= (grant != '0);
      if (grant != '0) flit_out <= flit_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= FULL;
    end else if (dec && !credit_in) begin
      credit_cnt <= credit_cnt - 1'b1;
    end else if (credit_in && !dec && credit_cnt != FULL) begin
      credit_cnt <= credit_cnt + 1'b1;
    end
  end

`ifdef OUTPUT_PORT_CREDIT_CHK_EN
  logic overflow;
  logic underflow;

  assign overflow  = credit_in && !dec && (credit_cnt == FULL);
  assign underflow = dec && (credit_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cred_err <= 1'b0;
    end else if (overflow || underflow) begin
      cred_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!underflow) else $error("output_port: grant issued with zero credits");
      assert (!overflow) else $warning("output_port: credit returned while counter full (width %0d)", CW);
    end
  end
`endif
`else
  assign cred_err = 1'b0;
`endif

endmodule

// File: tb/tb_output_port.sv
// Bench for output_port: integer-level model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_output_port;

  localparam int FW = 64;
  localparam int P  = 7;
  localparam int B  = 4;

`ifdef OUTPUT_PORT_CREDIT_CHK_EN
  localparam logic EXP_OVF_ERR = 1'b1;
`else
  localparam logic EXP_OVF_ERR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [P-1:0]    port_req;
  logic [P*FW-1:0] flits_in;
  logic [P-1:0]    grant;
  logic [FW-1:0]   flit_out;
  logic            flit_out_wr;
  logic            credit_in;
  logic [B:0]      credit_cnt;
  logic            cred_err;

  int errors = 0;
  int checks = 0;

  output_port #(.FW(FW), .P(P), .B(B)) dut (
    .clk         (clk),
    .rst         (rst),
    .port_req    (port_req),
    .flits_in    (flits_in),
    .grant       (grant),
    .flit_out    (flit_out),
    .flit_out_wr (flit_out_wr),
    .credit_in   (credit_in),
    .credit_cnt  (credit_cnt),
    .cred_err    (cred_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fv(input int i);
    return 64'hC0DE_0000_0000_0000 | (64'(i + 1) * 64'h0000_0000_0101_0101);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: integer pointer/counter, grant as winning index.
  int          m_ptr;
  int          m_cnt;
  int          m_win;
  logic [P-1:0] m_grant;
  logic [P-1:0] m_eff;
  logic [63:0]  m_flit;
  logic         m_wr;
  logic         m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = P - 1; m_cnt = 16; m_grant = '0; m_flit = '0; m_wr = 1'b0; m_err = 1'b0;
    end else begin
      m_eff = port_req & ~m_grant;
      m_win = -1;
      if (m_eff != '0 && m_cnt > 0)
        for (int k = 1; k <= P; k++)
          if (m_win < 0 && m_eff[(m_ptr + k) % P]) m_win = (m_ptr + k) % P;
      m_wr = (m_grant != '0);
      for (int i = 0; i < P; i++)
        if (m_grant[i]) m_flit = flits_in[i*FW +: FW];
      if (credit_in && m_win < 0 && m_cnt == 16 && EXP_OVF_ERR) m_err = 1'b1;
      m_cnt = m_cnt + (credit_in ? 1 : 0) - (m_win >= 0 ? 1 : 0);
      if (m_cnt > 16) m_cnt = 16;
      m_grant = '0;
      if (m_win >= 0) begin
        m_grant[m_win] = 1'b1;
        m_ptr = m_win;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("model_grant", 64'(grant), 64'(m_grant));
      chk("model_wr", 64'(flit_out_wr), 64'(m_wr));
      chk("model_flit", flit_out, m_flit);
      chk("model_cnt", 64'(credit_cnt), 64'(m_cnt));
      chk("model_err", 64'(cred_err), 64'(m_err));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    port_req  = '0;
    credit_in = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [P-1:0] seq [6];
  int           n;

  initial begin
    rst = 1'b1; port_req = '0; credit_in = 1'b0;
    for (int i = 0; i < P; i++) flits_in[i*FW +: FW] = fv(i);
    repeat (2) @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_wr", 64'(flit_out_wr), 64'd0);
    chk("rst_flit", flit_out, 64'd0);
    chk("rst_cnt", 64'(credit_cnt), 64'd16);
    chk("rst_err", 64'(cred_err), 64'd0);
    rst = 1'b0;

    // Single request from port 2.
    @(negedge clk); port_req = 7'b0000100;
    @(posedge clk); #2;
    chk("single_grant", 64'(grant), 64'b0000100);
    chk("single_cnt", 64'(credit_cnt), 64'd15);
    @(negedge clk); port_req = '0;
    @(posedge clk); #2;
    chk("single_wr", 64'(flit_out_wr), 64'd1);
    chk("single_flit", flit_out, fv(2));
    chk("single_grant_off", 64'(grant), 64'd0);
    @(posedge clk); #2;
    chk("single_wr_off", 64'(flit_out_wr), 64'd0);
    chk("single_flit_hold", flit_out, fv(2));

    // Fairness among ports 0, 3, 5.
    do_reset();
    port_req = 7'b0101001;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      seq[i] = grant;
    end
    @(negedge clk); port_req = '0;
    chk("fair_0", 64'(seq[0]), 64'b0000001);
    chk("fair_1", 64'(seq[1]), 64'b0001000);
    chk("fair_2", 64'(seq[2]), 64'b0100000);
    chk("fair_3", 64'(seq[3]), 64'b0000001);
    chk("fair_4", 64'(seq[4]), 64'b0001000);
    chk("fair_5", 64'(seq[5]), 64'b0100000);
    chk("fair_cnt", 64'(credit_cnt), 64'd10);

    // Credit exhaustion, then one returned credit.
    do_reset();
    port_req = 7'h7F;
    n = 0;
    repeat (24) begin
      @(posedge clk); #2;
      if (grant != '0) n++;
    end
    chk("exh_grants", 64'(n), 64'd16);
    chk("exh_cnt", 64'(credit_cnt), 64'd0);
    chk("exh_grant", 64'(grant), 64'd0);
    @(negedge clk); credit_in = 1'b1;
    @(posedge clk); #2;
    chk("cred0_nogrant", 64'(grant), 64'd0);
    chk("cred0_cnt", 64'(credit_cnt), 64'd1);
    @(negedge clk); credit_in = 1'b0;
    @(posedge clk); #2;
    chk("cred0_grant_next", 64'(grant != '0), 64'd1);
    chk("cred0_cnt_next", 64'(credit_cnt), 64'd0);
    n = 0;
    repeat (6) begin
      @(posedge clk); #2;
      if (grant != '0) n++;
    end
    chk("cred0_no_more", 64'(n), 64'd0);

    // Grant and credit return in the same cycle at count 5.
    do_reset();
    port_req = 7'h7F;
    repeat (11) @(posedge clk);
    #2;
    chk("sim_cnt_pre", 64'(credit_cnt), 64'd5);
    @(negedge clk); credit_in = 1'b1;
    @(posedge clk); #2;
    chk("sim_cnt", 64'(credit_cnt), 64'd5);
    chk("sim_grant", 64'(grant != '0), 64'd1);
    @(negedge clk); credit_in = 1'b0; port_req = '0;

    // Reset while a grant and a flit are in flight.
    do_reset();
    port_req = 7'b0010010;
    @(posedge clk);
    @(posedge clk); #2;
    chk("mid_grant_pre", 64'(grant), 64'b0010000);
    chk("mid_flit_pre", flit_out, fv(1));
    rst = 1'b1;
    #1;
    chk("mid_grant", 64'(grant), 64'd0);
    chk("mid_wr", 64'(flit_out_wr), 64'd0);
    chk("mid_flit", flit_out, 64'd0);
    chk("mid_cnt", 64'(credit_cnt), 64'd16);
    @(negedge clk); rst = 1'b0; port_req = 7'b1000001;
    @(posedge clk); #2;
    chk("mid_first_win", 64'(grant), 64'b0000001);
    @(negedge clk); port_req = '0;

    // Credit returned while already full.
    do_reset();
    @(negedge clk); credit_in = 1'b1;
    @(posedge clk); #2;
    chk("ovf_cnt", 64'(credit_cnt), 64'd16);
    chk("ovf_err", 64'(cred_err), 64'(EXP_OVF_ERR));
    @(negedge clk); credit_in = 1'b0;
    @(posedge clk); #2;
    chk("ovf_err_sticky", 64'(cred_err), 64'(EXP_OVF_ERR));

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
